// File: rtl/ram_block_mover.sv
// Block-transfer engine for the 16K x 16 data RAM: copies a run of words
// (memmove semantics, direction chosen to survive overlap) or fills a region.
module ram_block_mover (
  input  logic        CLK,
  input  logic        reset,
  input  logic        start,
  input  logic        fill,
  input  logic [13:0] src,
  input  logic [13:0] dst,
  input  logic [14:0] len,
  input  logic [15:0] fill_value,
  output logic        busy,
  output logic        done,
  output logic [13:0] ram_address,
  output logic [15:0] ram_in,
  output logic        ram_load,
  input  logic [15:0] ram_out
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t      r_state;
  logic [13:0] r_sp;
  logic [13:0] r_dp;
  logic [14:0] r_cnt;
  logic [15:0] r_buf;
  logic [15:0] r_fill_value;
  logic        r_fill;
  logic        r_back;

  logic [13:0] w_diff;
  logic [13:0] w_len_m1;
  logic        w_back;

  // Copy backward only when the destination starts inside the source run.
  assign w_diff   = dst - src;
  assign w_len_m1 = 14'(len - 15'd1);
  assign w_back   = !fill && (w_diff != 14'd0) && ({1'b0, w_diff} < len);

  always_ff @(posedge CLK) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_sp         <= '0;
      r_dp         <= '0;
      r_cnt        <= '0;
      r_buf        <= '0;
      r_fill_value <= '0;
      r_fill       <= 1'b0;
      r_back       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_fill       <= fill;
            r_fill_value <= fill_value;
            r_cnt        <= len;
            r_back       <= w_back;
            if (w_back) begin
              r_sp <= src + w_len_m1;
              r_dp <= dst + w_len_m1;
            end else begin
              r_sp <= src;
              r_dp <= dst;
            end
            if (len == 15'd0)
              r_state <= S_DONE;
            else if (fill)
              r_state <= S_WRITE;
            else
              r_state <= S_READ;
          end
        end
        S_READ: begin
          r_buf   <= ram_out;
          r_state <= S_WRITE;
        end
        S_WRITE: begin
          if (r_back) begin
            r_sp <= r_sp - 14'd1;
            r_dp <= r_dp - 14'd1;
          end else begin
            r_sp <= r_sp + 14'd1;
            r_dp <= r_dp + 14'd1;
          end
          r_cnt <= r_cnt - 15'd1;
          if (r_cnt == 15'd1)
            r_state <= S_DONE;
          else if (r_fill)
            r_state <= S_WRITE;
          else
            r_state <= S_READ;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy = (r_state == S_READ) || (r_state == S_WRITE);
  assign done = (r_state == S_DONE);

  always_comb begin
    ram_address = 14'd0;
    ram_in      = 16'd0;
    case (r_state)
      S_READ:  ram_address = r_sp;
      S_WRITE: begin
        ram_address = r_dp;
        ram_in      = r_fill ? r_fill_value : r_buf;
      end
      default: ;
    endcase
  end

  // Masking with reset makes an abort take effect in the very cycle it is
  // raised, so the write that would land on that edge is suppressed.
  assign ram_load = (r_state == S_WRITE) && !reset;

endmodule
